cnt_match_timer: RTL and testbench
==================================

Name: cnt_match_timer

Overview:
- Parametrised free-running / one-shot up-counter with a programmable terminal value and NUM_CMP independent compare channels.
- Each channel produces a level match flag and a single-cycle match event.
- Used as the general timer primitive for periodic strobes and timeouts; successor to the fixed two-compare enable counter.

Parameters:
CNT_WIDTH, 8, counter, top, load and compare width
NUM_CMP, 4, number of compare channels (>=1)
PRESC_WIDTH, 4, prescaler divider width (used only with the optional feature)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
clk_en  input  1  count enable qualifier
start  input  1  start/restart pulse
stop  input  1  stop pulse
load  input  1  load cnt from load_val
load_val  input  CNT_WIDTH  value for load
top  input  CNT_WIDTH  terminal count
oneshot  input  1  1 = one-shot mode, 0 = continuous mode
cmp_val  input  NUM_CMP x CNT_WIDTH  compare values, packed array
presc_div  input  PRESC_WIDTH  tick every presc_div+1 enabled cycles (port exists only with the feature)
cnt  output  CNT_WIDTH  current count (registered)
busy  output  1  state == RUN
flag  output  NUM_CMP  level: cnt == cmp_val[i] (combinational from registered cnt)
evt  output  NUM_CMP  1-cycle pulse, registered
wrap  output  1  1-cycle pulse, registered
done  output  1  1-cycle pulse, registered

Behaviour:
- Reset: state IDLE; cnt=0; evt, wrap, done=0; busy=0. flag follows cnt == cmp_val.
- States: IDLE, RUN, DONE.
- tick = (state==RUN) & clk_en & prescaler terminal. Without the feature, the prescaler terminal is always 1.
- Priority, per cycle: stop > load > start > tick.
- stop: from any state go to IDLE; cnt holds.
- load: cnt <= load_val; state unchanged; no evt/wrap/done generated.
- start: from IDLE or DONE, cnt <= 0 and go to RUN. In RUN, restart with cnt <= 0. No pulses.
- tick with cnt < top: cnt <= cnt+1.
- tick with cnt >= top:
  - continuous: cnt <= 0; wrap=1 next cycle.
  - one-shot: cnt holds; go to DONE; done=1 next cycle.
  - load_val > top therefore terminates on the next tick.
- evt[i] is asserted on the same cycle cnt first shows the new value, iff the tick updated cnt and the new cnt == cmp_val[i]. A one-shot hold at top is not an update, so no evt.
- Wrap to 0 with cmp_val[i]==0 asserts evt[i] together with wrap.
- top==0:
  - continuous: cnt stays 0; wrap on every tick.
  - one-shot: done on the first tick.
- Arithmetic is unsigned; cnt never exceeds 2^CNT_WIDTH-1 because termination uses >= top.
- Reset asserted mid-count: immediate return to reset values.
- cmp_val and top may change at any time and take effect on the next comparison.

Optional Feature:
CNT_MATCH_TIMER_PRESCALE_EN
- Defined:
  - presc_div port present; an internal PRESC_WIDTH prescaler counts clk_en cycles in RUN.
  - Terminal when presc_cnt == presc_div; then presc_cnt <= 0.
  - presc_cnt is cleared by reset, start, stop and load.
  - presc_div==0 gives a tick on every enabled cycle.
- Undefined: no port, no prescaler logic; tick = (state==RUN) & clk_en.

Decomposition:
- Package cnt_match_timer_pkg: state enum (IDLE, RUN, DONE); mode localparams MODE_CONT=0, MODE_ONESHOT=1.
- Sub-module timer_prescaler: presc counter plus terminal output. Instantiated only under the macro.
- Compare channels are a generate loop in the top module; no separate module.

Test Plan:
1. Reset release, CNT_WIDTH=8, top=5, continuous, start, clk_en=1 -> cnt 0,1,2,3,4,5,0; wrap high exactly on the cycle cnt returns to 0; busy=1 from the cycle after start.
2. cmp_val={3,0,7,5}, top=5 continuous -> evt[0] at cnt=3, evt[3] at cnt=5, evt[1] with each wrap, evt[2] never; flag levels match cnt.
3. One-shot, top=4 -> cnt stops at 4, done pulses once, state DONE, busy=0; further clk_en gives no pulses; start restarts from 0.
4. Same cycle stop+load+start during RUN -> IDLE, cnt holds previous value. Then load=1, load_val=200, top=10, start -> cnt=0 (start only in the next cycle). Also: load 200 in RUN -> next tick wraps to 0.
5. clk_en toggling 1,0,1,0 in RUN -> cnt advances only on enabled cycles. rst_n pulsed low mid-count -> all outputs return to reset values asynchronously.
6. (Macro defined) presc_div=2, top=3 -> cnt increments every 3 enabled cycles; wrap after 12 enabled cycles.

Source files
------------

// File: rtl/cnt_match_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnt_match_timer_pkg
// Brief    : Shared state encoding and mode constants for cnt_match_timer.
// Revision : 1.0 - initial release
// ============================================================================
package cnt_match_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_CONT    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/cnt_match_timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : timer_prescaler
// Brief    : Divides enabled cycles by i_div+1; o_term marks the ticking cycle.
// Revision : 1.0 - initial release
// ============================================================================
module timer_prescaler #(
  parameter int PRESC_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clr,
  input  logic                   i_en,
  input  logic [PRESC_WIDTH-1:0] i_div,
  output logic                   o_term
);

  logic [PRESC_WIDTH-1:0] r_presc_cnt;
  logic                   w_term;

  assign w_term = (r_presc_cnt == i_div);
  assign o_term = w_term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc_cnt <= '0;
    end else if (i_clr) begin
      r_presc_cnt <= '0;
    end else if (i_en) begin
      r_presc_cnt <= w_term ? '0 : r_presc_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cnt_match_timer.sv
`default_nettype none
// ============================================================================
// Module   : cnt_match_timer
// Brief    : Continuous/one-shot up-counter with terminal value and NUM_CMP
//            compare channels. CNT_MATCH_TIMER_PRESCALE_EN adds a prescaler.
// Revision : 1.0 - initial release
// ============================================================================
module cnt_match_timer
  import cnt_match_timer_pkg::*;
#(
  parameter int CNT_WIDTH   = 8,
  parameter int NUM_CMP     = 4,
  parameter int PRESC_WIDTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clk_en,
  input  logic                              start,
  input  logic                              stop,
  input  logic                              load,
  input  logic [CNT_WIDTH-1:0]              load_val,
  input  logic [CNT_WIDTH-1:0]              top,
  input  logic                              oneshot,
  input  logic [NUM_CMP-1:0][CNT_WIDTH-1:0] cmp_val,
`ifdef CNT_MATCH_TIMER_PRESCALE_EN
  input  logic [PRESC_WIDTH-1:0]            presc_div,
`endif
  output logic [CNT_WIDTH-1:0]              cnt,
  output logic                              busy,
  output logic [NUM_CMP-1:0]                flag,
  output logic [NUM_CMP-1:0]                evt,
  output logic                              wrap,
  output logic                              done
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 w_upd;
  logic                 w_wrap_nxt;
  logic                 w_done_nxt;
  logic                 w_run;
  logic                 w_presc_term;
  logic                 w_tick;
  logic                 r_wrap;
  logic                 r_done;

  assign w_run  = (r_state == RUN);
  assign w_tick = w_run & clk_en & w_presc_term;

`ifdef CNT_MATCH_TIMER_PRESCALE_EN
  timer_prescaler #(
    .PRESC_WIDTH(PRESC_WIDTH)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (stop | load | start),
    .i_en  (w_run & clk_en),
    .i_div (presc_div),
    .o_term(w_presc_term)
  );
`else
  assign w_presc_term = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wrap  <= w_wrap_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // w_upd marks a tick that actually changed cnt; a one-shot hold at top does not.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_upd       = 1'b0;
    w_wrap_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    if (stop) begin
      w_state_nxt = IDLE;
    end else if (load) begin
      w_cnt_nxt = load_val;
    end else if (start) begin
      w_cnt_nxt   = '0;
      w_state_nxt = RUN;
    end else if (w_tick) begin
      if (r_cnt >= top) begin
        if (oneshot == MODE_ONESHOT) begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt  = '0;
          w_upd      = 1'b1;
          w_wrap_nxt = 1'b1;
        end
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
        w_upd     = 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CMP; gi++) begin : g_cmp
      logic r_evt;

      assign flag[gi] = (r_cnt == cmp_val[gi]);
      assign evt[gi]  = r_evt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_evt <= 1'b0;
        end else begin
          r_evt <= w_upd & (w_cnt_nxt == cmp_val[gi]);
        end
      end
    end
  endgenerate

  assign cnt  = r_cnt;
  assign busy = w_run;
  assign wrap = r_wrap;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cnt_match_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnt_match_timer
// Brief    : Directed, table-driven self-checking bench for cnt_match_timer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnt_match_timer;

  localparam int CW = 8;
  localparam int NC = 4;
  localparam int PW = 4;

  logic               clk;
  logic               rst_n;
  logic               clk_en;
  logic               start;
  logic               stop;
  logic               load;
  logic [CW-1:0]      load_val;
  logic [CW-1:0]      top;
  logic               oneshot;
  logic [NC-1:0][CW-1:0] cmp_val;
`ifdef CNT_MATCH_TIMER_PRESCALE_EN
  logic [PW-1:0]      presc_div;
`endif
  logic [CW-1:0]      cnt;
  logic               busy;
  logic [NC-1:0]      flag;
  logic [NC-1:0]      evt;
  logic               wrap;
  logic               done;

  int n_pass;
  int n_total;

  cnt_match_timer #(
    .CNT_WIDTH  (CW),
    .NUM_CMP    (NC),
    .PRESC_WIDTH(PW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .start    (start),
    .stop     (stop),
    .load     (load),
    .load_val (load_val),
    .top      (top),
    .oneshot  (oneshot),
    .cmp_val  (cmp_val),
`ifdef CNT_MATCH_TIMER_PRESCALE_EN
    .presc_div(presc_div),
`endif
    .cnt      (cnt),
    .busy     (busy),
    .flag     (flag),
    .evt      (evt),
    .wrap     (wrap),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          en, st, sp, ld;
    logic [CW-1:0] lv, tp;
    logic          os;
    logic [CW-1:0] e_cnt;
    logic          e_busy, e_wrap, e_done;
    logic [NC-1:0] e_evt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, st, sp, ld, input int lv, tp, input logic os,
                     input int e_cnt, input logic e_busy, e_wrap, e_done,
                     input logic [NC-1:0] e_evt);
    vec_t v;
    v.en = en; v.st = st; v.sp = sp; v.ld = ld;
    v.lv = CW'(lv); v.tp = CW'(tp); v.os = os;
    v.e_cnt = CW'(e_cnt); v.e_busy = e_busy; v.e_wrap = e_wrap;
    v.e_done = e_done; v.e_evt = e_evt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic [NC-1:0] exp_flag(input logic [CW-1:0] c);
    logic [NC-1:0] f;
    for (int i = 0; i < NC; i++) f[i] = (c == cmp_val[i]);
    return f;
  endfunction

  task automatic chk_all(input string tag, input logic [CW-1:0] e_cnt,
                         input logic e_busy, e_wrap, e_done, input logic [NC-1:0] e_evt);
    chk({tag, ".cnt"},  int'(cnt),  int'(e_cnt));
    chk({tag, ".busy"}, int'(busy), int'(e_busy));
    chk({tag, ".wrap"}, int'(wrap), int'(e_wrap));
    chk({tag, ".done"}, int'(done), int'(e_done));
    chk({tag, ".evt"},  int'(evt),  int'(e_evt));
    chk({tag, ".flag"}, int'(flag), int'(exp_flag(e_cnt)));
  endtask

  task automatic drive(input logic en, st, sp, ld, input logic [CW-1:0] lv, tp, input logic os);
    clk_en = en; start = st; stop = sp; load = ld;
    load_val = lv; top = tp; oneshot = os;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd5, 1'b0);
    cmp_val[0] = 8'd3; cmp_val[1] = 8'd0; cmp_val[2] = 8'd7; cmp_val[3] = 8'd5;
`ifdef CNT_MATCH_TIMER_PRESCALE_EN
    presc_div = '0;
`endif

    //   en st sp ld  lv  top os   cnt busy wrap done evt
    add(1, 1, 0, 0,   0,  5, 0,    0, 1, 0, 0, 4'b0000); // start
    add(1, 0, 0, 0,   0,  5, 0,    1, 1, 0, 0, 4'b0000);
    add(1, 0, 0, 0,   0,  5, 0,    2, 1, 0, 0, 4'b0000);
    add(1, 0, 0, 0,   0,  5, 0,    3, 1, 0, 0, 4'b0001);
    add(1, 0, 0, 0,   0,  5, 0,    4, 1, 0, 0, 4'b0000);
    add(1, 0, 0, 0,   0,  5, 0,    5, 1, 0, 0, 4'b1000);
    add(1, 0, 0, 0,   0,  5, 0,    0, 1, 1, 0, 4'b0010); // wrap + evt[1]
    add(1, 0, 0, 0,   0,  5, 0,    1, 1, 0, 0, 4'b0000);
    add(0, 0, 0, 0,   0,  5, 0,    1, 1, 0, 0, 4'b0000); // clk_en low
    add(1, 0, 0, 0,   0,  5, 0,    2, 1, 0, 0, 4'b0000);
    add(0, 0, 0, 0,   0,  5, 0,    2, 1, 0, 0, 4'b0000);
    add(1, 0, 0, 0,   0,  5, 0,    3, 1, 0, 0, 4'b0001);
    add(1, 1, 1, 1,  99,  5, 0,    3, 0, 0, 0, 4'b0000); // stop wins
    add(1, 0, 0, 0,   0,  5, 0,    3, 0, 0, 0, 4'b0000); // idle: no count
    add(1, 1, 0, 1, 200, 10, 0,  200, 0, 0, 0, 4'b0000); // load beats start
    add(1, 1, 0, 0,   0, 10, 0,    0, 1, 0, 0, 4'b0000);
    add(1, 0, 0, 0,   0, 10, 0,    1, 1, 0, 0, 4'b0000);
    add(1, 0, 0, 1, 200, 10, 0,  200, 1, 0, 0, 4'b0000); // load in RUN
    add(1, 0, 0, 0,   0, 10, 0,    0, 1, 1, 0, 4'b0010); // beyond top wraps
    add(1, 0, 0, 0,   0, 10, 0,    1, 1, 0, 0, 4'b0000);
    add(1, 0, 1, 0,   0,  4, 1,    1, 0, 0, 0, 4'b0000); // stop
    add(1, 1, 0, 0,   0,  4, 1,    0, 1, 0, 0, 4'b0000); // one-shot top=4
    add(1, 0, 0, 0,   0,  4, 1,    1, 1, 0, 0, 4'b0000);
    add(1, 0, 0, 0,   0,  4, 1,    2, 1, 0, 0, 4'b0000);
    add(1, 0, 0, 0,   0,  4, 1,    3, 1, 0, 0, 4'b0001);
    add(1, 0, 0, 0,   0,  4, 1,    4, 1, 0, 0, 4'b0000);
    add(1, 0, 0, 0,   0,  4, 1,    4, 0, 0, 1, 4'b0000); // done, hold
    add(1, 0, 0, 0,   0,  4, 1,    4, 0, 0, 0, 4'b0000);
    add(1, 0, 0, 0,   0,  4, 1,    4, 0, 0, 0, 4'b0000);
    add(1, 1, 0, 0,   0,  4, 1,    0, 1, 0, 0, 4'b0000); // restart from DONE
    add(1, 0, 0, 0,   0,  4, 1,    1, 1, 0, 0, 4'b0000);
    add(1, 1, 0, 0,   0,  0, 0,    0, 1, 0, 0, 4'b0000); // top=0 continuous
    add(1, 0, 0, 0,   0,  0, 0,    0, 1, 1, 0, 4'b0010);
    add(1, 0, 0, 0,   0,  0, 0,    0, 1, 1, 0, 4'b0010);
    add(1, 1, 0, 0,   0,  0, 1,    0, 1, 0, 0, 4'b0000); // top=0 one-shot
    add(1, 0, 0, 0,   0,  0, 1,    0, 0, 0, 1, 4'b0000);

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 8'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].st, vecs[i].sp, vecs[i].ld, vecs[i].lv, vecs[i].tp, vecs[i].os);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_busy,
              vecs[i].e_wrap, vecs[i].e_done, vecs[i].e_evt);
    end

    // Asynchronous reset while evt[0] is high mid-count.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd5, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk_all("pre_rst", 8'd3, 1'b1, 1'b0, 1'b0, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 8'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("post_rst", 8'd0, 1'b0, 1'b0, 1'b0, 4'b0000);

`ifdef CNT_MATCH_TIMER_PRESCALE_EN
    // Divide-by-3 ticks: cnt steps every 3 enabled cycles, wrap on the 12th.
    presc_div = 4'd2;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd3, 1'b0);
    @(posedge clk); #1;
    chk_all("presc_start", 8'd0, 1'b1, 1'b0, 1'b0, 4'b0000);
    start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      logic [CW-1:0] ec;
      logic [NC-1:0] ee;
      @(posedge clk); #1;
      ec = (i < 12) ? CW'(i / 3) : 8'd0;
      ee = '0;
      if (i % 3 == 0) for (int k = 0; k < NC; k++) ee[k] = (ec == cmp_val[k]);
      chk_all($sformatf("presc%0d", i), ec, 1'b1, (i == 12), 1'b0, ee);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
